// File: rtl/calc_pkg.sv
// Shared calculator types: button indices,
// repeat-FSM states and counter sizing.
package calc_pkg;

  localparam int N_BUTTONS  = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  // A terminal count of 1 still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned
// level / press / release / pulse outputs.
interface button_conditioner_if #(
  parameter int N = calc_pkg::N_BUTTONS
);

  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_pulse
  );

endinterface

// File: rtl/button_conditioner_channel.sv
// One button: 2-FF sync, counter debounce,
// edge pulses and optional auto-repeat.
module button_channel
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000,
  parameter bit REPEAT_EN           = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_pulse
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RMAX =
    (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW = cnt_w(RMAX);

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST =
    RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST =
    RW'(REPEAT_RATE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  logic rise;
  logic fall;

  // btn_level lags stable by one cycle: edge detect.
  assign rise = stable & ~btn_level;
  assign fall = ~stable & btn_level;

  rpt_state_e    state;
  rpt_state_e    state_d;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_d;
  logic          tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_d;
      rcnt  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state;
    rcnt_d  = rcnt;
    tick    = 1'b0;
    if (!REPEAT_EN) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else if (fall) begin
      // Release wins over a coincident tick.
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_d = DELAY;
            rcnt_d  = '0;
          end
        end
        DELAY: begin
          if (rcnt == DLY_LAST) begin
            tick    = 1'b1;
            rcnt_d  = '0;
            state_d = REPEAT;
          end else begin
            rcnt_d = rcnt + RW'(1);
          end
        end
        REPEAT: begin
          if (rcnt == RATE_LAST) begin
            tick   = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt + RW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_pulse   <= 1'b0;
    end else begin
      btn_level   <= stable;
      btn_press   <= rise;
      btn_release <= fall;
      btn_pulse   <= rise | tick;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Basys3 push-button front end: one
// conditioning channel per button.
module button_conditioner #(
  parameter int N_BUTTONS           = calc_pkg::N_BUTTONS,
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK =
    N_BUTTONS'(5'b00011)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  logic [N_BUTTONS-1:0] level_v;
  logic [N_BUTTONS-1:0] press_v;
  logic [N_BUTTONS-1:0] release_v;
  logic [N_BUTTONS-1:0] pulse_v;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .REPEAT_EN          (REPEAT_MASK[i])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (bus.btn_raw[i]),
      .btn_level  (level_v[i]),
      .btn_press  (press_v[i]),
      .btn_release(release_v[i]),
      .btn_pulse  (pulse_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_pulse   = pulse_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: expected pulse
// events queued per scenario, matched to observed.
module tb_button_conditioner;

  typedef struct packed {
    int         cyc;
    logic [4:0] pr;
    logic [4:0] rl;
    logic [4:0] pu;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc     = 0;
  int   vectors = 0;
  int   errors  = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  button_conditioner_if #(.N(5)) bus ();

  button_conditioner #(
    .N_BUTTONS          (5),
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES (3),
    .REPEAT_MASK        (5'b00011)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && (bus.btn_press | bus.btn_release |
                  bus.btn_pulse) != 5'h0)
      obs_q.push_back('{cyc: cyc,
                        pr: bus.btn_press,
                        rl: bus.btn_release,
                        pu: bus.btn_pulse});
  end

  function automatic void add(input int c,
                              input logic [4:0] pr,
                              input logic [4:0] rl,
                              input logic [4:0] pu);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == c) begin
        exp_q[i].pr = exp_q[i].pr | pr;
        exp_q[i].rl = exp_q[i].rl | rl;
        exp_q[i].pu = exp_q[i].pu | pu;
        return;
      end
      if (exp_q[i].cyc > c) begin
        exp_q.insert(i, '{cyc: c, pr: pr, rl: rl, pu: pu});
        return;
      end
    end
    exp_q.push_back('{cyc: c, pr: pr, rl: rl, pu: pu});
  endfunction

  task automatic test_reset();
    ev_t e, o;
    int  e0, e1;
    rst_n = 1'b0;
    bus.btn_raw = 5'h1f;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release,
         bus.btn_pulse} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outs: got lv=%h pr=%h rl=%h pu=%h want 0",
               bus.btn_level, bus.btn_press,
               bus.btn_release, bus.btn_pulse);
    end
    rst_n = 1'b1;
    e0 = cyc + 1;
    add(e0 + 6, 5'h1f, 5'h00, 5'h1f);
    repeat (6) @(negedge clk);
    vectors++;
    if (bus.btn_level !== 5'h00) begin
      errors++;
      $display("FAIL reset_level_early: got %h want 00",
               bus.btn_level);
    end
    @(negedge clk);
    vectors++;
    if (bus.btn_level !== 5'h1f) begin
      errors++;
      $display("FAIL reset_level: got %h want 1f", bus.btn_level);
    end
    bus.btn_raw = 5'h00;
    e1 = cyc + 1;
    add(e1 + 6, 5'h00, 5'h1f, 5'h00);
    repeat (12) @(negedge clk);
    while (exp_q.size() + obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL reset_evt: got %0d extra, want %0d missing",
                 obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL reset_evt: got %0d/%h/%h/%h want %0d/%h/%h/%h",
                   o.cyc, o.pr, o.rl, o.pu, e.cyc, e.pr, e.rl, e.pu);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    ev_t e, o;
    int  e0, e1;
    @(negedge clk);
    bus.btn_raw[4] = 1'b1;
    e0 = cyc + 1;
    add(e0 + 6, 5'h10, 5'h00, 5'h10);
    repeat (30) @(negedge clk);
    bus.btn_raw[4] = 1'b0;
    e1 = cyc + 1;
    add(e1 + 6, 5'h00, 5'h10, 5'h00);
    repeat (10) @(negedge clk);
    while (exp_q.size() + obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL center_evt: got %0d extra, want %0d missing",
                 obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL center_evt: got %0d/%h/%h/%h want %0d/%h/%h/%h",
                   o.cyc, o.pr, o.rl, o.pu, e.cyc, e.pr, e.rl, e.pu);
        end
      end
    end
  endtask

  task automatic test_bounce();
    ev_t e, o;
    int  el, e1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.btn_raw[0] = (k % 2 == 0);
      @(negedge clk);
    end
    @(negedge clk);
    bus.btn_raw[0] = 1'b1;
    el = cyc + 1;
    add(el + 6, 5'h01, 5'h00, 5'h01);
    repeat (7) @(negedge clk);
    bus.btn_raw[0] = 1'b0;
    e1 = cyc + 1;
    add(e1 + 6, 5'h00, 5'h01, 5'h00);
    repeat (12) @(negedge clk);
    while (exp_q.size() + obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL bounce_evt: got %0d extra, want %0d missing",
                 obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL bounce_evt: got %0d/%h/%h/%h want %0d/%h/%h/%h",
                   o.cyc, o.pr, o.rl, o.pu, e.cyc, e.pr, e.rl, e.pu);
        end
      end
    end
  endtask

  task automatic test_glitch();
    ev_t e, o;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus.btn_level[2], bus.btn_press[2],
           bus.btn_pulse[2]} !== 3'b000) begin
        errors++;
        $display("FAIL glitch_k%0d: got lv/pr/pu=%b want 000", k,
                 {bus.btn_level[2], bus.btn_press[2],
                  bus.btn_pulse[2]});
      end
      bus.btn_raw[2] = (k < 3);
    end
    while (exp_q.size() + obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL glitch_evt: got %0d extra, want %0d missing",
                 obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL glitch_evt: got %0d/%h/%h/%h want %0d/%h/%h/%h",
                   o.cyc, o.pr, o.rl, o.pu, e.cyc, e.pr, e.rl, e.pu);
        end
      end
    end
  endtask

  task automatic test_repeat();
    ev_t e, o;
    int  p, e1;
    @(negedge clk);
    bus.btn_raw[0] = 1'b1;
    p = cyc + 7;
    add(p, 5'h01, 5'h00, 5'h01);
    // Release lands on the same edge as the P+46 tick.
    repeat (46) @(negedge clk);
    bus.btn_raw[0] = 1'b0;
    e1 = cyc + 1;
    for (int t = p + 10; t < e1 + 6; t += 3)
      add(t, 5'h00, 5'h00, 5'h01);
    add(e1 + 6, 5'h00, 5'h01, 5'h00);
    repeat (12) @(negedge clk);
    while (exp_q.size() + obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL repeat_evt: got %0d extra, want %0d missing",
                 obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL repeat_evt: got %0d/%h/%h/%h want %0d/%h/%h/%h",
                   o.cyc, o.pr, o.rl, o.pu, e.cyc, e.pr, e.rl, e.pu);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    int  p;
    @(negedge clk);
    bus.btn_raw = 5'h03;
    p = cyc + 7;
    add(p,      5'h03, 5'h00, 5'h03);
    add(p + 10, 5'h00, 5'h00, 5'h03);
    add(p + 13, 5'h00, 5'h00, 5'h03);
    add(p + 14, 5'h00, 5'h01, 5'h00);
    add(p + 16, 5'h00, 5'h00, 5'h02);
    add(p + 19, 5'h00, 5'h00, 5'h02);
    repeat (14) @(negedge clk);
    bus.btn_raw[0] = 1'b0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release,
         bus.btn_pulse} !== 20'h0) begin
      errors++;
      $display("FAIL b2b_reset: got lv=%h pr=%h rl=%h pu=%h want 0",
               bus.btn_level, bus.btn_press,
               bus.btn_release, bus.btn_pulse);
    end
    bus.btn_raw = 5'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    while (exp_q.size() + obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_evt: got %0d extra, want %0d missing",
                 obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL b2b_evt: got %0d/%h/%h/%h want %0d/%h/%h/%h",
                   o.cyc, o.pr, o.rl, o.pu, e.cyc, e.pr, e.rl, e.pu);
        end
      end
    end
  endtask

  initial begin
    bus.btn_raw = 5'h00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_repeat();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
